// File: rtl/datapath_multiciclo.sv
// Multicycle R-type/LW/SW datapath: FSM, 32-entry register file and data RAM.
// Optional feature: define DP_MULT_EN to add the MUL funct (011000).
module datapath_multiciclo #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 64,
    parameter int MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              cfg_we,
    input  logic [4:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              done,
    output logic [DATA_W-1:0] wb_data,
    output logic              zf,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
`ifdef DP_MULT_EN
    localparam logic [5:0] F_MUL  = 6'b011000;
`endif

    state_t             state;
    logic [31:0]        instr_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  alu_q;
    logic [DATA_W-1:0]  mem_q;

    logic [DATA_W-1:0]  regs [32];
    logic [DATA_W-1:0]  ram  [MEM_DEPTH];

    logic [5:0]         opcode;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [5:0]         funct;
    logic signed [15:0] imm_s;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  rd_a;
    logic [DATA_W-1:0]  rd_b;
    logic [DATA_W-1:0]  alu_res;
    logic               funct_ok;
    logic               is_legal;
    logic [MEM_AW-1:0]  mem_idx;
    logic [DATA_W-1:0]  wb_val;
    logic [4:0]         wb_dst;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;

    assign opcode   = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign rd       = instr_q[15:11];
    assign funct    = instr_q[5:0];
    assign imm_s    = instr_q[15:0];
    assign imm_ext  = DATA_W'(imm_s);

    assign rd_a     = (rs == 5'd0) ? '0 : regs[rs];
    assign rd_b     = (rt == 5'd0) ? '0 : regs[rt];

    assign mem_idx  = alu_q[MEM_AW-1:0];
    assign wb_val   = (opcode == OP_LW) ? mem_q : alu_q;
    assign wb_dst   = (opcode == OP_LW) ? rt : rd;
    assign in_ready = (state == S_IDLE);

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: funct_ok = 1'b1;
`ifdef DP_MULT_EN
            F_MUL:                                    funct_ok = 1'b1;
`endif
            default:                                  funct_ok = 1'b0;
        endcase
    end

    assign is_legal = ((opcode == OP_R) && funct_ok) ||
                      (opcode == OP_LW) || (opcode == OP_SW);

    // Loads and stores reuse the adder to form the effective address.
    always_comb begin
        alu_res = '0;
        if (opcode != OP_R) begin
            alu_res = a_q + imm_ext;
        end else begin
            case (funct)
                F_ADD:   alu_res = a_q + b_q;
                F_SUB:   alu_res = a_q - b_q;
                F_AND:   alu_res = a_q & b_q;
                F_OR:    alu_res = a_q | b_q;
                F_NOR:   alu_res = ~(a_q | b_q);
                F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
`ifdef DP_MULT_EN
                F_MUL:   alu_res = a_q * b_q;
`endif
                default: alu_res = '0;
            endcase
        end
    end

    // The single write port is shared by write-back and the idle-time preload.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wb_dst;
        rf_wdata = wb_val;
        if (state == S_WB) begin
            rf_we = 1'b1;
        end else if ((state == S_IDLE) && cfg_we && !in_valid) begin
            rf_we    = 1'b1;
            rf_waddr = cfg_addr;
            rf_wdata = cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (state == S_MEM) && (opcode == OP_SW)) begin
            ram[mem_idx] <= b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mem_q   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            zf      <= 1'b0;
            wb_data <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        instr_q <= instr;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= rd_a;
                    b_q <= rd_b;
                    if (!is_legal) begin
                        illegal <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    zf    <= (alu_res == '0);
                    state <= (opcode == OP_R) ? S_WB : S_MEM;
                end
                S_MEM: begin
                    if (opcode == OP_LW) begin
                        mem_q <= ram[mem_idx];
                        state <= S_WB;
                    end else begin
                        wb_data <= b_q;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_WB: begin
                    wb_data <= wb_val;
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_multiciclo.sv
// Scoreboard bench for datapath_multiciclo: a behavioural model predicts each retirement.
module tb_datapath_multiciclo;

    typedef struct {
        logic        ill;
        logic [31:0] wb;
        logic        zf;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        done;
    logic [31:0] wb_data;
    logic        zf;
    logic        illegal;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int acc_cycle = 0;

    exp_t        sb_q[$];
    logic [31:0] bm_regs [32];
    logic [31:0] bm_ram  [64];
    logic        bm_zf;

    datapath_multiciclo dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .done     (done),
        .wb_data  (wb_data),
        .zf       (zf),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] f);
        return {6'b000000, s, t, d, 5'b00000, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) bm_regs[i] = '0;
        bm_zf = 1'b0;
    endtask

    task automatic modelStep(input logic [31:0] ins, output exp_t e);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  s;
        logic [4:0]  t;
        logic [4:0]  d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic [31:0] res;
        op  = ins[31:26];
        s   = ins[25:21];
        t   = ins[20:16];
        d   = ins[15:11];
        fn  = ins[5:0];
        a   = bm_regs[s];
        b   = bm_regs[t];
        sum = a + {{16{ins[15]}}, ins[15:0]};
        res = '0;
        e.ill = 1'b0;
        e.lat = 3;
        e.wb  = '0;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: res = a + b;
                    6'b100010: res = a - b;
                    6'b100100: res = a & b;
                    6'b100101: res = a | b;
                    6'b100111: res = ~(a | b);
                    6'b101010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef DP_MULT_EN
                    6'b011000: res = a * b;
`endif
                    default:   e.ill = 1'b1;
                endcase
                if (!e.ill) begin
                    bm_zf = (res == 0);
                    if (d != 0) bm_regs[d] = res;
                    e.wb = res;
                end
            end
            6'b100011: begin
                e.lat = 4;
                bm_zf = (sum == 0);
                res   = bm_ram[sum[5:0]];
                if (t != 0) bm_regs[t] = res;
                e.wb  = res;
            end
            6'b101011: begin
                bm_zf = (sum == 0);
                bm_ram[sum[5:0]] = b;
                e.wb  = b;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) e.lat = 1;
        e.zf = bm_zf;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (a != 0) bm_regs[a] = d;
    endtask

    // Drives one instruction, optionally with a cfg write that must be ignored,
    // then waits a bounded time for the monitor to retire it.
    task automatic applyStimulus(input logic [31:0] ins, input logic cfg_too);
        exp_t e;
        @(negedge clk);
        checkOutput("ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        instr    = ins;
        if (cfg_too) begin
            cfg_we   = 1'b1;
            cfg_addr = 5'd14;
            cfg_data = 32'd99;
        end
        modelStep(ins, e);
        sb_q.push_back(e);
        @(negedge clk);
        acc_cycle = cycle;
        in_valid  = 1'b0;
        checkOutput("ready_busy", in_ready, 1'b0);
        @(negedge clk);
        cfg_we = 1'b0;
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checkOutput("retire_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (done || illegal)) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_retire", {done, illegal}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("illegal", illegal, e.ill);
                checkOutput("done", done, !e.ill);
                checkOutput("latency", cycle - acc_cycle, e.lat);
                if (!e.ill) checkOutput("wb_data", wb_data, e.wb);
                checkOutput("zf", zf, e.zf);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ready", in_ready, 1'b1);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_illegal", illegal, 1'b0);
        checkOutput("rst_zf", zf, 1'b0);
        checkOutput("rst_wb", wb_data, 32'd0);

        preload(5'd1, 32'd5);
        preload(5'd2, 32'd5);
        applyStimulus(rtype(5'd1, 5'd2, 5'd3, 6'b100010), 1'b0);
        applyStimulus(rtype(5'd3, 5'd0, 5'd9, 6'b100000), 1'b0);

        preload(5'd4, 32'd7);
        applyStimulus(itype(6'b101011, 5'd0, 5'd4, 16'd3), 1'b0);
        applyStimulus(itype(6'b100011, 5'd0, 5'd5, 16'd3), 1'b0);
        applyStimulus(rtype(5'd5, 5'd0, 5'd6, 6'b100000), 1'b0);

        preload(5'd1, 32'd62);
        preload(5'd4, 32'd9);
        applyStimulus(itype(6'b101011, 5'd1, 5'd4, 16'd5), 1'b0);
        applyStimulus(itype(6'b100011, 5'd0, 5'd7, 16'd3), 1'b0);
        preload(5'd1, 32'd3);
        preload(5'd4, 32'd11);
        applyStimulus(itype(6'b101011, 5'd1, 5'd4, 16'hFFFF), 1'b0);
        applyStimulus(itype(6'b100011, 5'd0, 5'd7, 16'd2), 1'b0);

        preload(5'd1, 32'd6);
        preload(5'd2, 32'd7);
        applyStimulus(rtype(5'd1, 5'd2, 5'd3, 6'b100100), 1'b0);
        applyStimulus(itype(6'b111111, 5'd1, 5'd2, 16'h1820), 1'b0);
        applyStimulus(rtype(5'd1, 5'd2, 5'd11, 6'b011000), 1'b0);
        applyStimulus(rtype(5'd11, 5'd0, 5'd12, 6'b100000), 1'b0);
        applyStimulus(rtype(5'd1, 5'd2, 5'd3, 6'b100101), 1'b0);
        applyStimulus(rtype(5'd1, 5'd2, 5'd3, 6'b100111), 1'b0);

        preload(5'd1, 32'd1);
        preload(5'd2, 32'd2);
        applyStimulus(rtype(5'd1, 5'd2, 5'd0, 6'b100000), 1'b0);
        applyStimulus(rtype(5'd0, 5'd0, 5'd9, 6'b100000), 1'b0);
        preload(5'd1, 32'hFFFF_FFFF);
        preload(5'd2, 32'd1);
        applyStimulus(rtype(5'd1, 5'd2, 5'd13, 6'b101010), 1'b0);
        applyStimulus(rtype(5'd2, 5'd1, 5'd13, 6'b101010), 1'b0);

        applyStimulus(rtype(5'd1, 5'd2, 5'd3, 6'b100000), 1'b1);
        applyStimulus(rtype(5'd14, 5'd0, 5'd15, 6'b100000), 1'b0);

        // Abort an ADD by pulsing reset while it sits in EXEC.
        preload(5'd1, 32'd1);
        preload(5'd2, 32'd2);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = rtype(5'd1, 5'd2, 5'd8, 6'b100000);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkOutput("abort_ready", in_ready, 1'b1);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_zf", zf, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("abort_quiet", done, 1'b0);
        applyStimulus(rtype(5'd8, 5'd0, 5'd9, 6'b100000), 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
